// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the arbiter and the shared UART transmitter.
// The master side is the producer/transmitter environment; the arbiter uses the slave side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_start;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic                      frame_done;

  modport master (
    output req_valid, req_data,
    input  req_ready, tx_data, tx_start, grant_id, busy, frame_done
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, tx_data, tx_start, grant_id, busy, frame_done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers,
// timing each frame and the idle gap that follows it by counting baud ticks.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int FRAME_BITS = 10,
  parameter int GAP_TICKS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               baud_rate_signal,
  uart_tx_arbiter_if.slave   bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND, GAP} state_t;

  state_t            state;
  logic [ID_W-1:0]   last;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic [ID_W-1:0]   winner;
  logic [DATA_W-1:0] winner_data;
  logic              found;

  // Rank each requester by its distance after the last winner; lowest valid rank wins.
  always_comb begin
    int rank;
    int best;
    winner      = last;
    winner_data = '0;
    found       = 1'b0;
    best        = NUM_REQ;
    rank        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rank = (i + NUM_REQ - 1 - int'(last)) % NUM_REQ;
      if (bus.req_valid[i] && (rank < best)) begin
        best        = rank;
        winner      = ID_W'(i);
        winner_data = bus.req_data[i*DATA_W +: DATA_W];
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last           <= ID_W'(NUM_REQ - 1);
      bit_cnt        <= '0;
      gap_cnt        <= '0;
      bus.req_ready  <= '0;
      bus.tx_data    <= '0;
      bus.tx_start   <= 1'b0;
      bus.grant_id   <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.req_ready  <= '0;
      bus.frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // A tick landing on the grant edge is deliberately not treated as the launch tick.
          if (enable && found) begin
            bus.req_ready <= NUM_REQ'(1) << winner;
            bus.tx_data   <= winner_data;
            bus.grant_id  <= winner;
            last          <= winner;
            bus.tx_start  <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (baud_rate_signal) begin
            bus.tx_start <= 1'b0;
            bit_cnt      <= '0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (baud_rate_signal) begin
            if (bit_cnt == BIT_LAST) begin
              bus.frame_done <= 1'b1;
              if (GAP_TICKS == 0) begin
                bus.busy <= 1'b0;
                state    <= IDLE;
              end else begin
                gap_cnt <= '0;
                state   <= GAP;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        GAP: begin
          if (baud_rate_signal) begin
            if (gap_cnt == GAP_LAST) begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
